lcd_digit_writer: RTL and testbench
===================================

Name: lcd_digit_writer

Overview:
Sequences the write of a 3-digit ASCII field to an HD44780-style character LCD over its 8-bit parallel bus. On a start pulse it captures the three ASCII digits from the BCD-to-ASCII converter. It then issues one "set DDRAM address" command followed by three data writes (hundreds, tens, units), generating RS, E and data timing. It sits between the BCD-to-ASCII converter and the LCD pins and reports busy and done to the top-level display controller.

Parameters:
SETUP_CYC, 2, cycles RS/data are valid with E low before E rises (>=1)
E_HIGH_CYC, 12, cycles E is held high (>=1)
WAIT_CYC, 2000, cycles after E falls before the next write; covers LCD execution time, ~40 us at 50 MHz (1..65535)
DDRAM_ADDR, 7'h40, DDRAM address of the hundreds digit

Ports:
clk  input  1  system clock, single clock domain
rst_n  input  1  asynchronous active-low reset
start  input  1  request to write the field; sampled only in IDLE
ascii_2  input  8  hundreds digit, ASCII
ascii_1  input  8  tens digit, ASCII
ascii_0  input  8  units digit, ASCII
lcd_rs  output  1  LCD register select: 0 = command, 1 = data
lcd_rw  output  1  LCD read/write, constant 0 (write only)
lcd_e  output  1  LCD enable strobe
lcd_data  output  8  LCD data bus
busy  output  1  high while a sequence is in progress
done  output  1  one-cycle pulse when a sequence completes

Behaviour:
- Reset (async, rst_n=0): state IDLE; lcd_rs, lcd_rw, lcd_e, busy, done = 0; lcd_data = 8'h00; digit index = 0; cycle counter = 0. Takes effect immediately, including mid-sequence. An aborted sequence produces no done pulse.
- States: IDLE, SETUP, EHIGH, WAIT, DONE.
- IDLE: start=1 at edge T captures ascii_2/1/0 into internal registers and sets index = 0. From cycle T+1: state SETUP, busy = 1.
- Write order by index:
  - 0: RS=0, data = {1'b1, DDRAM_ADDR}
  - 1: RS=1, data = ascii_2
  - 2: RS=1, data = ascii_1
  - 3: RS=1, data = ascii_0
- Per write:
  - SETUP: SETUP_CYC cycles, E=0.
  - EHIGH: E_HIGH_CYC cycles, E=1.
  - WAIT: WAIT_CYC cycles, E=0.
  - RS and data are stable across all three phases. They change only when entering SETUP of the next write.
- WAIT end:
  - If index < 3: index += 1 and go to SETUP.
  - If index = 3: go to DONE.
- DONE: exactly one cycle with done = 1 and busy = 0, then IDLE. lcd_data and lcd_rs keep their last values until the next sequence.
- Latency: with N = SETUP_CYC + E_HIGH_CYC + WAIT_CYC, done is high during cycle T+1+4N. The first E rise occurs at T+1+SETUP_CYC.
- Cycle counter is 16 bits and reloads on every phase entry. Phase lengths are exact; no off-by-one between phases.
- start while busy or in DONE is ignored; it is neither queued nor counted.
- Captured digits are used for the whole sequence. Changes on ascii_* after capture have no effect.
- Non-digit ASCII values, e.g. 8'h2B '+', are written unchanged; there is no validation.
- Exactly 4 E pulses per sequence. E never high in IDLE or DONE.

Test Plan:
1. Reset, then SETUP=2, E_HIGH=3, WAIT=4, DDRAM_ADDR=7'h40; start at T with ascii_2/1/0 = 8'h31/8'h32/8'h33 -> bus shows (RS0,8'hC0), (RS1,8'h31), (RS1,8'h32), (RS1,8'h33), each with E high 3 cycles; first E rise at T+3; done high in cycle T+37 only.
2. Same parameters; toggle ascii_* to 8'h39 and pulse start again at T+10 -> written digits remain 31/32/33; exactly 4 E pulses; one done pulse; no second sequence begins.
3. Assert rst_n=0 asynchronously while in EHIGH of write 2 -> lcd_e, busy, lcd_rs = 0 and lcd_data = 8'h00 immediately; no done pulse; a new start after release runs a full 4-write sequence.
4. Input ascii_0 = 8'h2B -> last data write is 8'h2B with RS=1.
5. Start held high continuously for 100 cycles -> back-to-back sequences, each separated by one DONE cycle plus one IDLE cycle, with done pulsing once per sequence.
6. Default parameters (2/12/2000) -> per-write period 2014 cycles; done exactly 8057 cycles after the start edge.

Source files
------------

// File: rtl/lcd_digit_writer_if.sv
// Bus between the display controller / ASCII source and the LCD digit writer.
// The writer takes the slave side; the controller or bench takes the master side.
interface lcd_digit_writer_if;
    logic       start;
    logic [7:0] ascii_2;
    logic [7:0] ascii_1;
    logic [7:0] ascii_0;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_data;
    logic       busy;
    logic       done;

    modport master (
        output start, ascii_2, ascii_1, ascii_0,
        input  lcd_rs, lcd_rw, lcd_e, lcd_data, busy, done
    );

    modport slave (
        input  start, ascii_2, ascii_1, ascii_0,
        output lcd_rs, lcd_rw, lcd_e, lcd_data, busy, done
    );
endinterface

// File: rtl/lcd_digit_writer.sv
// Writes a 3-digit ASCII field to an HD44780-style LCD: one DDRAM address
// command, then hundreds/tens/units data writes, each with setup/E-high/wait phases.
module lcd_digit_writer #(
    parameter int         SETUP_CYC  = 2,
    parameter int         E_HIGH_CYC = 12,
    parameter int         WAIT_CYC   = 2000,
    parameter logic [6:0] DDRAM_ADDR = 7'h40
) (
    input logic               clk,
    input logic               rst_n,
    lcd_digit_writer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, EHIGH, WAIT, DONE} state_t;

    localparam logic [15:0] SETUP_LD = 16'(SETUP_CYC - 1);
    localparam logic [15:0] EHIGH_LD = 16'(E_HIGH_CYC - 1);
    localparam logic [15:0] WAIT_LD  = 16'(WAIT_CYC - 1);

    state_t      state, state_nx;
    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [7:0]  dig_2, dig_1, dig_0;
    logic [7:0]  next_digit;
    logic        phase_end;

    assign phase_end = (cnt == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = SETUP;
            SETUP:   if (phase_end) state_nx = EHIGH;
            EHIGH:   if (phase_end) state_nx = WAIT;
            WAIT:    if (phase_end) state_nx = (idx == 2'd3) ? DONE : SETUP;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.lcd_rw = 1'b0;
        bus.lcd_e  = (state == EHIGH);
        bus.busy   = (state == SETUP) || (state == EHIGH) || (state == WAIT);
        bus.done   = (state == DONE);
    end

    // idx still names the write just finished; the next one takes the following digit
    always_comb begin
        case (idx)
            2'd0:    next_digit = dig_2;
            2'd1:    next_digit = dig_1;
            default: next_digit = dig_0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= 16'd0;
            idx          <= 2'd0;
            dig_2        <= 8'h00;
            dig_1        <= 8'h00;
            dig_0        <= 8'h00;
            bus.lcd_rs   <= 1'b0;
            bus.lcd_data <= 8'h00;
        end else begin
            if (state_nx != state) begin
                case (state_nx)
                    SETUP:   cnt <= SETUP_LD;
                    EHIGH:   cnt <= EHIGH_LD;
                    WAIT:    cnt <= WAIT_LD;
                    default: cnt <= 16'd0;
                endcase
            end else if (!phase_end) begin
                cnt <= cnt - 16'd1;
            end

            // RS/data only move on entry to SETUP, so they hold through E and the wait
            if (state == IDLE && state_nx == SETUP) begin
                dig_2        <= bus.ascii_2;
                dig_1        <= bus.ascii_1;
                dig_0        <= bus.ascii_0;
                idx          <= 2'd0;
                bus.lcd_rs   <= 1'b0;
                bus.lcd_data <= {1'b1, DDRAM_ADDR};
            end else if (state == WAIT && state_nx == SETUP) begin
                idx          <= idx + 2'd1;
                bus.lcd_rs   <= 1'b1;
                bus.lcd_data <= next_digit;
            end
        end
    end
endmodule

// File: tb/tb_lcd_digit_writer.sv
// Bench for lcd_digit_writer: a timeline model predicts every bus cycle, plus
// directed sequences with hand-computed timing and a default-parameter instance.
module tb_lcd_digit_writer;
    localparam int S  = 2;
    localparam int EH = 3;
    localparam int W  = 4;
    localparam int N  = S + EH + W;
    localparam int L  = 4 * N;
    localparam logic [6:0] ADDR = 7'h40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_digit_writer_if bus ();
    lcd_digit_writer_if bus2 ();

    lcd_digit_writer #(.SETUP_CYC(S), .E_HIGH_CYC(EH), .WAIT_CYC(W), .DDRAM_ADDR(ADDR))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    lcd_digit_writer dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // timeline model: m_pos counts cycles since the accepting edge
    bit         m_act = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_d [3];
    logic       m_rs = 1'b0;
    logic [7:0] m_data = 8'h00;

    logic       prev_e = 1'b0;
    logic       prev_e2 = 1'b0;
    int         rise_cyc [$];
    logic [8:0] rise_val [$];
    int         done_cyc [$];
    int         acc_cyc [$];
    int         ehigh_tot = 0;
    int         r2 [$];
    int         d2 [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        logic [12:0] act, exp;
        int w, p;
        logic e, bsy, dn;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_act = 1'b0; m_rs = 1'b0; m_data = 8'h00;
            end else if (m_act) begin
                if (m_pos == L) m_act = 1'b0;
                else            m_pos++;
            end else if (bus.start) begin
                m_act = 1'b1; m_pos = 0;
                m_d[0] = bus.ascii_2; m_d[1] = bus.ascii_1; m_d[2] = bus.ascii_0;
                acc_cyc.push_back(cyc);
            end
            #1;
            e = 1'b0; bsy = 1'b0; dn = 1'b0;
            if (m_act && m_pos < L) begin
                w = m_pos / N;
                p = m_pos % N;
                e = (p >= S) && (p < S + EH);
                bsy = 1'b1;
                m_rs = (w != 0);
                m_data = (w == 0) ? {1'b1, ADDR} : m_d[w-1];
            end else if (m_act) begin
                dn = 1'b1;
            end
            exp = {m_rs, 1'b0, e, bsy, dn, m_data};
            act = {bus.lcd_rs, bus.lcd_rw, bus.lcd_e, bus.busy, bus.done, bus.lcd_data};
            chk("cycle", {19'd0, act}, {19'd0, exp});

            if (bus.lcd_e && !prev_e) begin
                rise_cyc.push_back(cyc);
                rise_val.push_back({bus.lcd_rs, bus.lcd_data});
            end
            if (bus.lcd_e) ehigh_tot++;
            if (bus.done) done_cyc.push_back(cyc);
            prev_e = bus.lcd_e;
            if (bus2.lcd_e && !prev_e2) r2.push_back(cyc);
            if (bus2.done) d2.push_back(cyc);
            prev_e2 = bus2.lcd_e;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int lim, input string nm);
        int k = 0;
        while (done_cyc.size() <= base && k < lim) begin
            tick(1);
            k++;
        end
        if (done_cyc.size() <= base) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic run_seq(input logic [7:0] h, t, u, output int r0, output int d0, output int a0);
        bus.ascii_2 = h; bus.ascii_1 = t; bus.ascii_0 = u;
        r0 = rise_cyc.size(); d0 = done_cyc.size(); a0 = acc_cyc.size();
        pulse();
        wait_done(d0, 100, "seq");
        tick(2);
    endtask

    task automatic chk_seq(input string nm, input int r0, input int d0, input logic [7:0] h, t, u);
        chk({nm, "_pulses"}, rise_cyc.size() - r0, 4);
        chk({nm, "_dones"}, done_cyc.size() - d0, 1);
        if (rise_val.size() - r0 == 4) begin
            chk({nm, "_w0"}, {23'd0, rise_val[r0]},   {23'd0, 1'b0, 8'hC0});
            chk({nm, "_w1"}, {23'd0, rise_val[r0+1]}, {23'd0, 1'b1, h});
            chk({nm, "_w2"}, {23'd0, rise_val[r0+2]}, {23'd0, 1'b1, t});
            chk({nm, "_w3"}, {23'd0, rise_val[r0+3]}, {23'd0, 1'b1, u});
        end
    endtask

    initial begin
        int r0, d0, a0, e0, k, a2;
        bus.start = 1'b0; bus.ascii_2 = 8'h00; bus.ascii_1 = 8'h00; bus.ascii_0 = 8'h00;
        bus2.start = 1'b0; bus2.ascii_2 = 8'h31; bus2.ascii_1 = 8'h32; bus2.ascii_0 = 8'h33;
        fork
            compare_loop();
        join_none

        tick(3);
        chk("reset_outs", {19'd0, bus.lcd_rs, bus.lcd_rw, bus.lcd_e, bus.busy, bus.done, bus.lcd_data}, 0);
        rst_n = 1'b1;
        tick(2);

        // basic field; the bench counts the accepting edge as cycle T, its following cycle as T+1
        e0 = ehigh_tot;
        run_seq(8'h31, 8'h32, 8'h33, r0, d0, a0);
        chk_seq("t1", r0, d0, 8'h31, 8'h32, 8'h33);
        chk("t1_first_rise", rise_cyc[r0] - acc_cyc[a0] + 1, 3);
        chk("t1_done_at", done_cyc[d0] - acc_cyc[a0] + 1, 37);
        chk("t1_ehigh_cycles", ehigh_tot - e0, 12);

        // inputs change and start re-pulses mid-sequence
        r0 = rise_cyc.size(); d0 = done_cyc.size(); a0 = acc_cyc.size();
        pulse();
        tick(9);
        bus.ascii_2 = 8'h39; bus.ascii_1 = 8'h39; bus.ascii_0 = 8'h39;
        pulse();
        wait_done(d0, 100, "t2");
        tick(6);
        chk_seq("t2", r0, d0, 8'h31, 8'h32, 8'h33);
        chk("t2_accepts", acc_cyc.size() - a0, 1);
        chk("t2_idle_busy", {31'd0, bus.busy}, 0);

        // async reset in EHIGH of the second data write (index 2)
        bus.ascii_2 = 8'h34; bus.ascii_1 = 8'h35; bus.ascii_0 = 8'h36;
        d0 = done_cyc.size();
        pulse();
        tick(2 * N + S);
        chk("t3_in_ehigh", {23'd0, bus.lcd_e, bus.lcd_data}, {23'd0, 1'b1, 8'h35});
        #2 rst_n = 1'b0;
        #1 chk("t3_async", {19'd0, bus.lcd_rs, bus.lcd_rw, bus.lcd_e, bus.busy, bus.done, bus.lcd_data}, 0);
        tick(3);
        rst_n = 1'b1;
        tick(L + 4);
        chk("t3_no_done", done_cyc.size() - d0, 0);
        run_seq(8'h37, 8'h38, 8'h39, r0, d0, a0);
        chk_seq("t3_restart", r0, d0, 8'h37, 8'h38, 8'h39);

        // non-digit passes through untouched
        run_seq(8'h30, 8'h30, 8'h2B, r0, d0, a0);
        chk_seq("t4", r0, d0, 8'h30, 8'h30, 8'h2B);

        // start held: back-to-back with DONE + IDLE between
        r0 = rise_cyc.size(); d0 = done_cyc.size(); a0 = acc_cyc.size();
        bus.ascii_2 = 8'h31; bus.ascii_1 = 8'h32; bus.ascii_0 = 8'h33;
        bus.start = 1'b1;
        tick(100);
        bus.start = 1'b0;
        wait_done(d0 + 2, 200, "t5");
        tick(L + 10);
        chk("t5_dones", done_cyc.size() - d0, 3);
        chk("t5_accepts", acc_cyc.size() - a0, 3);
        chk("t5_pulses", rise_cyc.size() - r0, 12);
        if (done_cyc.size() - d0 >= 2) chk("t5_gap", done_cyc[d0+1] - done_cyc[d0], L + 2);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bus.start = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) begin
                bus.ascii_2 = 8'($urandom); bus.ascii_1 = 8'($urandom); bus.ascii_0 = 8'($urandom);
            end
            tick(1);
        end
        bus.start = 1'b0;
        k = 0;
        while (bus.busy && k < 100) begin tick(1); k++; end
        if (bus.busy) chk("rand_idle_timeout", 0, 1);
        tick(3);

        // default-parameter instance: 2014-cycle writes
        bus2.start = 1'b1;
        a2 = cyc + 1;
        tick(1);
        bus2.start = 1'b0;
        k = 0;
        while (d2.size() == 0 && k < 9000) begin tick(1); k++; end
        if (d2.size() == 0) chk("t6_timeout", 0, 1);
        tick(3);
        chk("t6_pulses", r2.size(), 4);
        chk("t6_dones", d2.size(), 1);
        if (r2.size() >= 2) begin
            chk("t6_first_rise", r2[0] - a2 + 1, 3);
            chk("t6_period", r2[1] - r2[0], 2014);
        end
        if (d2.size() >= 1) chk("t6_done_at", d2[0] - a2 + 1, 8057);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
